alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Execution-side consumer of the 4-bit ALU operation code from ALU_Control. Accepts
//  {op, A, B} via valid/ready, computes result and zero flag, returns them via valid/ready.
//  Shifts run serially (1 bit/clk); all other ops take one cycle. Sits between decode and writeback.
// PARAMETERS
//  DATA_WIDTH   32   operand/result width
//  SHAMT_WIDTH  5    shift-amount bits taken from B[SHAMT_WIDTH-1:0]; must equal clog2(DATA_WIDTH)
// PORTS
//  clk               in   1            clock, all state on rising edge
//  reset             in   1            synchronous, active-high reset
//  alu_operation_i   in   4            op code (encoding below)
//  data_a_i          in   DATA_WIDTH   operand A
//  data_b_i          in   DATA_WIDTH   operand B / shift amount
//  op_valid_i        in   1            request valid
//  op_ready_o        out  1            block can accept a request
//  result_o          out  DATA_WIDTH   registered result
//  zero_o            out  1            result_o == 0
//  result_valid_o    out  1            result_o/zero_o valid
//  result_ready_i    in   1            consumer takes result
// BEHAVIOUR
//  - Op codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA,
//    1000 PASSB (LUI), 1001 SLT (signed), 1010 SLTU; 1011-1111 -> result 0, 1-cycle path.
//  - ADD/SUB wrap modulo 2^DATA_WIDTH, no carry/overflow out. SLT/SLTU result is 0 or 1, zero-extended.
//  - FSM: IDLE, SHIFT, DONE. op_ready_o = (state==IDLE).
//  - IDLE: on op_valid_i && op_ready_o capture op, A, B[SHAMT_WIDTH-1:0].
//    non-shift op -> result registered, go DONE (valid 1 clk after accept).
//    shift op, shamt==0 -> result=A, go DONE (1 clk).
//    shift op, shamt>0 -> load working reg=A, counter=shamt, go SHIFT.
//  - SHIFT: each clk shift working reg 1 bit (SLL: fill 0; SRL: fill 0; SRA: fill old MSB),
//    counter-=1; when counter reaches 0 load result, go DONE. Shift latency = shamt+1 clk after accept.
//  - DONE: result_valid_o=1, result_o/zero_o stable; on result_ready_i go IDLE. No new request
//    accepted in DONE (max throughput 1 op / 2 clk). result_ready_i outside DONE is ignored.
//  - Inputs need only be valid in the accept cycle; later changes have no effect.
//  - op_valid_i while busy: ignored, requester must hold until op_ready_o.
//  - reset (any state, incl. mid-shift): state=IDLE, result_o=0, result_valid_o=0, counter=0;
//    in-flight op discarded, no result emitted. zero_o=1 after reset (follows result_o=0).
//  - zero_o is combinational from result_o register only (no input-to-output comb paths).
// CONFIGURATION
//  ALU_SEQ_BARREL_SHIFT_EN defined: shifts computed by barrel shifter in one clk, SHIFT state
//    and counter removed; every op has 1-clk latency.
//  Not defined (default): serial shifter as above.
// TESTING
//  1 reset, then ADD A=5 B=7 -> result_valid_o 1 clk after accept, result_o=12, zero_o=0.
//  2 SUB A=9 B=9 -> result_o=0, zero_o=1; SUB A=0 B=1 -> 0xFFFFFFFF (wrap).
//  3 SRA A=0x80000000 B=4 -> op_ready_o low 4 clk, valid at clk 5, result_o=0xF8000000
//    (macro on: valid at clk 1, same value).
//  4 SLL A=1 B=0x25 (shamt 5) -> result_o=0x20; SLT A=-1 B=1 -> 1; SLTU A=-1 B=1 -> 0.
//  5 hold result_ready_i=0 for 3 clk in DONE -> result_o stable, op_valid_i with new op ignored
//    until ready pulse; then new op accepted.
//  6 SRL A=0xFF B=8, assert reset at 3rd SHIFT clk -> IDLE, result_valid_o=0, result_o=0, no result.

Source files
------------

// File: rtl/alu_seq_exec.sv
// ALU execution stage: valid/ready request in, registered result + zero flag out.
// Shifts are serial (1 bit/clk) unless ALU_SEQ_BARREL_SHIFT_EN is defined (single-cycle barrel shifter).
//
// state   | meaning
// S_IDLE  | ready for a request, op_ready_o high
// S_SHIFT | serial shift in progress (absent in barrel build)
// S_DONE  | result_o/zero_o held valid until result_ready_i
module alu_seq_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_PASSB = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  // Single-cycle datapath. In the serial build shifts only reach here with shamt==0, so they return A.
  function automatic logic [DATA_WIDTH-1:0] alu_calc(input logic [3:0]            op,
                                                     input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      OP_SLL:   r = a << b[SHAMT_WIDTH-1:0];
      OP_SRL:   r = a >> b[SHAMT_WIDTH-1:0];
      OP_SRA:   r = $unsigned($signed(a) >>> b[SHAMT_WIDTH-1:0]);
`else
      OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
      OP_PASSB: r = b;
      OP_SLT:   r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default:  r = '0;
    endcase
    return r;
  endfunction

`ifndef ALU_SEQ_BARREL_SHIFT_EN
  logic [3:0]             op_q, op_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SHAMT_WIDTH-1:0] shamt_in;
  logic                   shift_req;
  logic [DATA_WIDTH-1:0]  work_step;

  assign shamt_in  = data_b_i[SHAMT_WIDTH-1:0];
  assign shift_req = (alu_operation_i == OP_SLL) || (alu_operation_i == OP_SRL) ||
                     (alu_operation_i == OP_SRA);

  always_comb begin
    work_step = '0;
    case (op_q)
      OP_SLL:  work_step = {work_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  work_step = {1'b0, work_q[DATA_WIDTH-1:1]};
      default: work_step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid_i) begin
`ifndef ALU_SEQ_BARREL_SHIFT_EN
          if (shift_req && (shamt_in != '0)) begin
            op_d    = alu_operation_i;
            work_d  = data_a_i;
            cnt_d   = shamt_in;
            state_d = S_SHIFT;
          end else
`endif
          begin
            result_d = alu_calc(alu_operation_i, data_a_i, data_b_i);
            state_d  = S_DONE;
          end
        end
      end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      S_SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q - SHAMT_WIDTH'(1);
        // Last step lands directly in result so DONE starts shamt+1 clocks after accept.
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d = work_step;
          state_d  = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (result_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      op_q     <= OP_ADD;
      work_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign op_ready_o     = (state_q == S_IDLE);
  assign result_valid_o = (state_q == S_DONE);
  assign result_o       = result_q;
  assign zero_o         = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: scoreboard of expected results, per-scenario tasks.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] da = '0;
  logic [31:0] db = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] result;
  logic        zero;
  logic        result_valid;
  logic        result_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb_q[$];
  int          lat_q[$];

  alu_seq_exec dut (
    .clk            (clk),
    .reset          (reset),
    .alu_operation_i(alu_op),
    .data_a_i       (da),
    .data_b_i       (db),
    .op_valid_i     (op_valid),
    .op_ready_o     (op_ready),
    .result_o       (result),
    .zero_o         (zero),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return $unsigned($signed(a) >>> sh);
      4'd8:    return b;
      4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10:   return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    return 1;
`else
    if ((op >= 4'd5) && (op <= 4'd7) && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Drive one request; expectation is pushed at the accept edge. Inputs are scrambled afterwards.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    @(negedge clk);
    while (!op_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      to = 1'b1;
      return;
    end
    alu_op   = op;
    da       = a;
    db       = b;
    op_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back(model(op, a, b));
    lat_q.push_back(model_lat(op, b));
    #1;
    op_valid = 1'b0;
    alu_op   = 4'($urandom);
    da       = $urandom;
    db       = $urandom;
  endtask

  // Wait for result_valid (latency counted in clocks after accept), then take it.
  task automatic get_result(output logic [31:0] r, output logic z, output int lat,
                            output int rdy_hi, output bit to);
    lat    = 0;
    rdy_hi = 0;
    to     = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (result_valid) break;
      if (op_ready) rdy_hi++;
      if (lat >= 100) begin
        to = 1'b1;
        return;
      end
    end
    r = result;
    z = zero;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h exp 0", result); end
    tests++;
    if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero got %b exp 1", zero); end
    tests++;
    if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", result_valid); end
    tests++;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", op_ready); end
  endtask

  // Directed table from the block description plus edge cases and a random sweep.
  task automatic test_ops();
    logic [3:0]  t_op[14] = '{4'd0, 4'd1, 4'd1, 4'd5, 4'd9, 4'd10, 4'd2, 4'd3,
                              4'd4, 4'd8, 4'd11, 4'd7, 4'd5, 4'd15};
    logic [31:0] t_a[14]  = '{32'd5, 32'd9, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hF0F0_1234, 32'h0F00_0001, 32'hAAAA_5555, 32'h1234_5678,
                              32'h55, 32'h8000_0001, 32'h1, 32'h77};
    logic [31:0] t_b[14]  = '{32'd7, 32'd9, 32'd1, 32'h25, 32'd1, 32'd1,
                              32'h0FF0_FF00, 32'h00F0_0010, 32'hFFFF_0000, 32'hABCD_0000,
                              32'h66, 32'hFFFF_FFE0, 32'd31, 32'd3};
    logic [31:0] r, e;
    logic        z;
    int          lat, rdy_hi, el;
    bit          to;
    for (int i = 0; i < 34; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      if (i < 14) begin
        op = t_op[i]; a = t_a[i]; b = t_b[i];
      end else begin
        op = 4'($urandom_range(0, 12));
        a  = $urandom;
        b  = {$urandom_range(0, 7) == 0 ? 27'd0 : 27'($urandom), 5'($urandom_range(0, 9))};
      end
      send(op, a, b, to);
      tests++;
      if (to) begin fails++; $display("FAIL ops_send_timeout idx %0d", i); continue; end
      get_result(r, z, lat, rdy_hi, to);
      e  = sb_q.pop_front();
      el = lat_q.pop_front();
      tests++;
      if (to) begin fails++; $display("FAIL ops_result_timeout idx %0d", i); continue; end
      tests++;
      if (r !== e) begin fails++; $display("FAIL ops_result idx %0d op %0d got %h exp %h", i, op, r, e); end
      tests++;
      if (z !== (e == 32'd0)) begin fails++; $display("FAIL ops_zero idx %0d got %b exp %b", i, z, e == 32'd0); end
      tests++;
      if (lat !== el) begin fails++; $display("FAIL ops_latency idx %0d got %0d exp %0d", i, lat, el); end
      tests++;
      if (rdy_hi !== 0) begin fails++; $display("FAIL ops_busy_ready idx %0d ready high %0d clks exp 0", i, rdy_hi); end
    end
  endtask

  task automatic test_sra_timing();
    logic [31:0] r, e;
    logic        z;
    int          lat, rdy_hi, el;
    bit          to;
    send(4'd7, 32'h8000_0000, 32'd4, to);
    tests++;
    if (to) begin fails++; $display("FAIL sra_send_timeout"); return; end
    get_result(r, z, lat, rdy_hi, to);
    e  = sb_q.pop_front();
    el = lat_q.pop_front();
    tests++;
    if (to) begin fails++; $display("FAIL sra_result_timeout"); return; end
    tests++;
    if (r !== 32'hF800_0000 || e !== 32'hF800_0000) begin
      fails++; $display("FAIL sra_result got %h exp F8000000", r);
    end
    tests++;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    if (lat !== 1) begin fails++; $display("FAIL sra_latency got %0d exp 1", lat); end
`else
    if (lat !== 5 || el !== 5) begin fails++; $display("FAIL sra_latency got %0d exp 5", lat); end
`endif
    tests++;
    if (rdy_hi !== 0) begin fails++; $display("FAIL sra_ready_low ready high %0d clks exp 0", rdy_hi); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, e;
    logic        z;
    int          n, lat, rdy_hi;
    bit          to;
    send(4'd0, 32'd100, 32'd23, to);
    tests++;
    if (to) begin fails++; $display("FAIL bp_send_timeout"); return; end
    n = 0;
    @(negedge clk);
    while (!result_valid && n < 60) begin @(negedge clk); n++; end
    e = sb_q.pop_front();
    void'(lat_q.pop_front());
    tests++;
    if (!result_valid) begin fails++; $display("FAIL bp_valid_timeout"); return; end
    alu_op   = 4'd1;
    da       = 32'd50;
    db       = 32'd8;
    op_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (result !== e || result_valid !== 1'b1) begin
        fails++; $display("FAIL bp_hold clk %0d got %h/%b exp %h/1", k, result, result_valid, e);
      end
      tests++;
      if (op_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_in_done clk %0d got %b exp 0", k, op_ready); end
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    sb_q.push_back(model(4'd1, 32'd50, 32'd8));
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    da       = 32'd0;
    get_result(r, z, lat, rdy_hi, to);
    e = sb_q.pop_front();
    tests++;
    if (to) begin fails++; $display("FAIL bp_second_timeout"); return; end
    tests++;
    if (r !== e || e !== 32'd42) begin fails++; $display("FAIL bp_second_result got %h exp %h", r, 32'd42); end
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL bp_second_latency got %0d exp 1", lat); end
  endtask

  task automatic test_reset_midshift();
    bit to;
    int seen;
    send(4'd6, 32'h0000_00FF, 32'd8, to);
    tests++;
    if (to) begin fails++; $display("FAIL rst_send_timeout"); return; end
    repeat (3) @(negedge clk);
    tests++;
    if (op_ready !== 1'b0) begin fails++; $display("FAIL rst_busy_ready got %b exp 0", op_ready); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(sb_q.pop_back());
    void'(lat_q.pop_back());
    @(negedge clk);
    tests++;
    if (result_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b exp 0", result_valid); end
    tests++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      fails++; $display("FAIL rst_mid_result got %h/%b exp 0/1", result, zero);
    end
    tests++;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got %b exp 1", op_ready); end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL rst_no_result got %0d valid clks exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_sra_timing();
    test_backpressure();
    test_reset_midshift();
    tests++;
    if (sb_q.size() !== 0) begin fails++; $display("FAIL scoreboard_leftover got %0d exp 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
